regfile_dump: RTL and testbench

Debug/readout engine on the register-file read side. On `start` it sweeps a programmable address window through one read port (address out, combinational data in). It streams each register value out on a valid/ready interface, tagged with its address. Used by the ALU verification harness and the debug path to snapshot architectural state without stalling the write port.

---
 rtl/regfile_dump.sv | 218 +++++++++++++++++++++
 tb/tb_regfile_dump.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: debug/readout engine on the register-file read side.
//
// When start is seen in IDLE, the block latches a window [first_addr .. last_addr].
// It then walks that window through one read port of the register file.
// Each word is streamed out on a valid/ready interface, tagged with its address.
// Addresses wrap modulo 2**ADDR_W, so first_addr > last_addr wraps through the top of
// the address space. An equal pair dumps exactly one register.
//
// Optional build macro: REGDUMP_CHECKSUM_EN
//   When defined, an XOR of every delivered register word is appended as one extra beat.
//   That beat has out_addr = last_addr and out_last = 1.
//   out_last stays low on all register beats in this mode.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            dump request, only honoured in IDLE
//   first_addr       first register of the window, sampled with start
//   last_addr        last register of the window, sampled with start
//   abort            synchronous cancel of an active dump
//   rf_rd_addr       registered read address to the register file
//   rf_rd_data       combinational read data for rf_rd_addr
//   out_valid        beat handshake, valid half
//   out_ready        beat handshake, ready half
//   out_data         register value of the current beat
//   out_addr         address of out_data
//   out_last         final beat of the dump
//   busy             engine not idle
//   done             one-cycle pulse on normal completion

module regfile_dump #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StSend  = 3'd2;
    localparam logic [2:0] StDone  = 3'd3;
`ifdef REGDUMP_CHECKSUM_EN
    localparam logic [2:0] StCksum = 3'd4;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic handshake;
    logic load_word;
    logic ptr_at_end;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    // Set when the beat on out_* is the final register of the window.
    // out_last is reserved for the checksum beat in this mode.
    logic              fin_q, fin_d;
`endif

    assign handshake  = out_valid_q && out_ready;
    assign ptr_at_end = (ptr_q == end_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        end_d       = end_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load_word   = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d       = acc_q;
        fin_d       = fin_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d   = first_addr;
                    end_d   = last_addr;
                    state_d = StLoad;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end

            // rf_rd_addr already points at the first register; capture it.
            StLoad: begin
                load_word = 1'b1;
                state_d   = StSend;
            end

            StSend: begin
                if (handshake) begin
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d = acc_q ^ out_data_q;
                    if (fin_q) begin
                        // Fold in the beat being accepted right now.
                        out_data_d = acc_q ^ out_data_q;
                        out_addr_d = end_q;
                        out_last_d = 1'b1;
                        state_d    = StCksum;
                    end else begin
                        load_word = 1'b1;
                    end
`else
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = StDone;
                    end else begin
                        load_word = 1'b1;
                    end
`endif
                end
            end

`ifdef REGDUMP_CHECKSUM_EN
            StCksum: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = StDone;
                end
            end
`endif

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Present the register at ptr and step to the next address.
        // The address wraps naturally at 2**ADDR_W.
        if (load_word) begin
            out_data_d  = rf_rd_data;
            out_addr_d  = ptr_q;
            out_valid_d = 1'b1;
            ptr_d       = ptr_q + 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            fin_d       = ptr_at_end;
            out_last_d  = 1'b0;
`else
            out_last_d  = ptr_at_end;
`endif
        end

        // Abort wins over everything, including a handshake in the same cycle.
        // That beat still counts as delivered.
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            end_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q       <= '0;
            fin_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            end_q       <= end_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q       <= acc_d;
            fin_q       <= fin_d;
`endif
        end
    end

    assign rf_rd_addr = ptr_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != StIdle);
    // An abort landing on the DONE cycle suppresses the completion pulse.
    assign done       = (state_q == StDone) && !abort;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed dumps over a modelled register file.

module tb_regfile_dump;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [AW+DW:0] beat_t;  // {last, addr, data}

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rf_rd_addr;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] rf_rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [32];
    beat_t         exp_q [$];
    int            checks = 0;
    int            failures = 0;

    assign rf_rd_data = rf[rf_rd_addr];

    always #5 clk = ~clk;

    regfile_dump #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_addr(first_addr),
        .last_addr (last_addr),
        .abort     (abort),
        .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
    endtask

    // Expected beat list for a window, including the checksum beat when enabled.
    function automatic void build_exp(input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] a   = f;
        logic [AW-1:0] span = l - f;
        logic [DW-1:0] acc = '0;
        int            n   = int'(span) + 1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(!CK && (i == n - 1)), a, rf[a]});
            acc = acc ^ rf[a];
            a   = a + 1'b1;
        end
        if (CK) exp_q.push_back({1'b1, l, acc});
    endfunction

    task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({rf_rd_addr, out_data, out_addr, out_valid, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rf_rd_addr, out_data, out_addr, out_valid, out_last, busy, done});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset: got %b required 000", {out_valid, busy, done});
        end
    endtask

    task automatic test_full();
        fill_pattern();
        out_ready = 1'b1;
        build_exp(5'd0, 5'd31);
        do_start(5'd0, 5'd31);
        checks++;
        if ({out_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL full_latency: got valid/busy %b required 01", {out_valid, busy});
        end
        tick();
        checks++;
        if ({out_valid, out_addr, out_data} !== {1'b1, 5'd0, 32'd0}) begin
            failures++;
            $display("FAIL full_first_beat: got %h required %h",
                     {out_valid, out_addr, out_data}, {1'b1, 5'd0, 32'd0});
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if ({out_valid, out_last, out_addr, out_data} !== {1'b1, exp_q[k]}) begin
                failures++;
                $display("FAIL full_beat %0d: got %h required %h", k,
                         {out_valid, out_last, out_addr, out_data}, {1'b1, exp_q[k]});
            end
            tick();
        end
        checks++;
        if ({out_valid, done, busy} !== 3'b011) begin
            failures++;
            $display("FAIL full_done: got valid/done/busy %b required 011",
                     {out_valid, done, busy});
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL full_idle: got done/busy %b required 00", {done, busy});
        end
    endtask

    task automatic test_wrap();
        fill_pattern();
        out_ready = 1'b1;
        build_exp(5'd30, 5'd1);
        do_start(5'd30, 5'd1);
        tick();
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if ({out_valid, out_last, out_addr, out_data} !== {1'b1, exp_q[k]}) begin
                failures++;
                $display("FAIL wrap_beat %0d: got %h required %h", k,
                         {out_valid, out_last, out_addr, out_data}, {1'b1, exp_q[k]});
            end
            tick();
        end
        checks++;
        if ({out_valid, done} !== 2'b01) begin
            failures++;
            $display("FAIL wrap_done: got valid/done %b required 01", {out_valid, done});
        end
        tick();
    endtask

    task automatic test_single_stall();
        fill_pattern();
        rf[7]     = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        build_exp(5'd7, 5'd7);
        do_start(5'd7, 5'd7);
        tick();
        checks++;
        if ({out_addr, out_data} !== {5'd7, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL single_word: got %h required %h", {out_addr, out_data},
                     {5'd7, 32'hDEAD_BEEF});
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({out_valid, out_last, out_addr, out_data} !== {1'b1, exp_q[0]}) begin
                failures++;
                $display("FAIL single_hold cycle %0d: got %h required %h", c,
                         {out_valid, out_last, out_addr, out_data}, {1'b1, exp_q[0]});
            end
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if ({out_valid, out_last, out_addr, out_data} !== {1'b1, exp_q[k]}) begin
                failures++;
                $display("FAIL single_beat %0d: got %h required %h", k,
                         {out_valid, out_last, out_addr, out_data}, {1'b1, exp_q[k]});
            end
            tick();
        end
        checks++;
        if ({out_valid, done} !== 2'b01) begin
            failures++;
            $display("FAIL single_done: got valid/done %b required 01", {out_valid, done});
        end
        tick();
    endtask

    task automatic test_toggle_ready();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int k = 0;
        fill_pattern();
        out_ready = 1'b0;
        build_exp(5'd0, 5'd31);
        do_start(5'd0, 5'd31);
        tick();
        for (int c = 0; c < 400 && k < exp_q.size(); c++) begin
            out_ready = pat[c % 4];
            checks++;
            if ({out_valid, out_last, out_addr, out_data} !== {1'b1, exp_q[k]}) begin
                failures++;
                $display("FAIL toggle_beat %0d cycle %0d: got %h required %h", k, c,
                         {out_valid, out_last, out_addr, out_data}, {1'b1, exp_q[k]});
            end
            if (out_ready) k++;
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (k != exp_q.size()) begin
            failures++;
            $display("FAIL toggle_count: got %0d beats required %0d", k, exp_q.size());
        end
        checks++;
        if ({out_valid, done} !== 2'b01) begin
            failures++;
            $display("FAIL toggle_done: got valid/done %b required 01", {out_valid, done});
        end
        tick();
    endtask

    task automatic test_abort();
        fill_pattern();
        out_ready = 1'b1;
        build_exp(5'd0, 5'd31);
        do_start(5'd0, 5'd31);
        tick();
        for (int k = 0; k < 5; k++) begin
            // A second start while busy must not disturb the running dump.
            start      = (k == 2);
            first_addr = 5'd10;
            last_addr  = 5'd12;
            checks++;
            if ({out_valid, out_last, out_addr, out_data} !== {1'b1, exp_q[k]}) begin
                failures++;
                $display("FAIL abort_beat %0d: got %h required %h", k,
                         {out_valid, out_last, out_addr, out_data}, {1'b1, exp_q[k]});
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b1;
        checks++;
        if ({out_valid, out_addr, done} !== {1'b1, 5'd5, 1'b0}) begin
            failures++;
            $display("FAIL abort_cycle: got valid/addr/done %h required %h",
                     {out_valid, out_addr, done}, {1'b1, 5'd5, 1'b0});
        end
        tick();
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({out_valid, out_last, busy, done} !== 4'b0000) begin
                failures++;
                $display("FAIL abort_idle cycle %0d: got %b required 0000", c,
                         {out_valid, out_last, busy, done});
            end
            tick();
        end
        // Abort together with start in IDLE: start is taken.
        build_exp(5'd3, 5'd5);
        abort = 1'b1;
        do_start(5'd3, 5'd5);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_busy: got %b required 1", busy);
        end
        tick();
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if ({out_valid, out_last, out_addr, out_data} !== {1'b1, exp_q[k]}) begin
                failures++;
                $display("FAIL restart_beat %0d: got %h required %h", k,
                         {out_valid, out_last, out_addr, out_data}, {1'b1, exp_q[k]});
            end
            tick();
        end
        checks++;
        if ({out_valid, done} !== 2'b01) begin
            failures++;
            $display("FAIL restart_done: got valid/done %b required 01", {out_valid, done});
        end
        tick();
    endtask

    task automatic test_small_window();
        beat_t tbl [$];
        fill_pattern();
        rf[1] = 32'd1;
        rf[2] = 32'd2;
        rf[3] = 32'd3;
        rf[4] = 32'd4;
`ifdef REGDUMP_CHECKSUM_EN
        tbl = '{{1'b0, 5'd1, 32'd1}, {1'b0, 5'd2, 32'd2}, {1'b0, 5'd3, 32'd3},
                {1'b0, 5'd4, 32'd4}, {1'b1, 5'd4, 32'h0000_0004}};
`else
        tbl = '{{1'b0, 5'd1, 32'd1}, {1'b0, 5'd2, 32'd2}, {1'b0, 5'd3, 32'd3},
                {1'b1, 5'd4, 32'd4}};
`endif
        out_ready = 1'b1;
        do_start(5'd1, 5'd4);
        tick();
        for (int k = 0; k < tbl.size(); k++) begin
            checks++;
            if ({out_valid, out_last, out_addr, out_data} !== {1'b1, tbl[k]}) begin
                failures++;
                $display("FAIL small_beat %0d: got %h required %h", k,
                         {out_valid, out_last, out_addr, out_data}, {1'b1, tbl[k]});
            end
            tick();
        end
        checks++;
        if ({out_valid, done} !== 2'b01) begin
            failures++;
            $display("FAIL small_done: got valid/done %b required 01", {out_valid, done});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        fill_pattern();
        out_ready = 1'b1;
        do_start(5'd0, 5'd31);
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rf_rd_addr, out_data, out_addr, out_valid, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_async: got %h required 0",
                     {rf_rd_addr, out_data, out_addr, out_valid, out_last, busy, done});
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release: got %b required 000", {out_valid, busy, done});
        end
    endtask

    initial begin
        fill_pattern();
        test_reset();
        test_full();
        test_wrap();
        test_single_stall();
        test_toggle_ready();
        test_abort();
        test_small_window();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
